// File: rtl/mem_bus_initiator_if.sv
// rtl/mem_bus_initiator_if.sv - command, response and 6502-style bus signals of the initiator
interface mem_bus_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [15:0] bus_addr;
  logic        bus_rwb;
  logic        bus_phi2;
  logic [7:0]  bus_dout;
  logic        bus_doe;
  logic [7:0]  bus_din;
  logic        bus_rdy;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, bus_din, bus_rdy,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           bus_addr, bus_rwb, bus_phi2, bus_dout, bus_doe
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, bus_din, bus_rdy,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           bus_addr, bus_rwb, bus_phi2, bus_dout, bus_doe
  );
endinterface

// File: rtl/mem_bus_initiator.sv
// rtl/mem_bus_initiator.sv - single-command initiator for a 6502-style phi2 memory bus
module mem_bus_initiator #(
  parameter int HALF_CYCLES = 2,
  parameter int MAX_WAIT    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_bus_initiator_if.master  mbi
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_WAIT,
    ST_HOLD
  } state_t;

  localparam logic [7:0] HALF_LAST = 8'(HALF_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       timeout;
  logic       accept;

  assign mbi.cmd_ready = (state == ST_IDLE);
  assign accept        = mbi.cmd_valid && (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // One counter serves both phase timing and wait-state counting; it is
  // cleared on every state change so each phase starts from zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mbi.cmd_valid) begin
          state_nxt = ST_SETUP;
          cnt_nxt   = 8'd0;
        end
      end
      ST_SETUP: begin
        if (cnt == HALF_LAST) begin
          state_nxt = ST_ACCESS;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ST_ACCESS: begin
        if (cnt == HALF_LAST) begin
          state_nxt = mbi.bus_rdy ? ST_HOLD : ST_WAIT;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ST_WAIT: begin
        if (mbi.bus_rdy) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = 8'd0;
        end else if (cnt == WAIT_LAST) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = 8'd0;
          timeout   = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ST_HOLD: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Bus outputs are registered from the next state so they change together
  // with the state; bus_rwb doubles as the latched command direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbi.bus_addr  <= 16'h0000;
      mbi.bus_rwb   <= 1'b1;
      mbi.bus_phi2  <= 1'b0;
      mbi.bus_dout  <= 8'h00;
      mbi.bus_doe   <= 1'b0;
      mbi.rsp_valid <= 1'b0;
      mbi.rsp_rdata <= 8'h00;
      mbi.rsp_err   <= 1'b0;
    end else begin
      mbi.bus_phi2  <= (state_nxt == ST_ACCESS) || (state_nxt == ST_WAIT);
      mbi.rsp_valid <= (state_nxt == ST_HOLD);
      mbi.rsp_err   <= timeout;
      if (accept) begin
        mbi.bus_addr <= mbi.cmd_addr;
        mbi.bus_rwb  <= mbi.cmd_rw;
        mbi.bus_dout <= mbi.cmd_wdata;
        mbi.bus_doe  <= ~mbi.cmd_rw;
      end else if (state == ST_HOLD) begin
        mbi.bus_rwb <= 1'b1;
        mbi.bus_doe <= 1'b0;
      end
      // Read data is captured only on the edge where phi2 falls.
      if (state_nxt == ST_HOLD) begin
        mbi.rsp_rdata <= (timeout || !mbi.bus_rwb) ? 8'h00 : mbi.bus_din;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// tb/tb_mem_bus_initiator.sv - self-checking bench for mem_bus_initiator
module tb_mem_bus_initiator;

  localparam int HALF  = 2;
  localparam int MAXW  = 4;
  localparam int NRAND = 40;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mem_bus_initiator_if mbi();

  mem_bus_initiator #(.HALF_CYCLES(HALF), .MAX_WAIT(MAXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mbi   (mbi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    int          k;
    logic [7:0]  exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // k = number of consecutive cycles bus_rdy is low, starting at the last ACCESS cycle.
  task automatic model(input logic rw, input logic [7:0] din, input int k,
                       output logic [7:0] rdata, output logic err, output int lat);
    int waits;
    waits = (k < MAXW) ? k : MAXW;
    err   = (k > MAXW);
    lat   = 2 * HALF + 1 + waits;
    rdata = (err || !rw) ? 8'h00 : din;
  endtask

  task automatic run_txn(input logic rw, input logic [15:0] addr, input logic [7:0] wdata,
                         input logic [7:0] din, input int k, input bit noise,
                         output int lat, output logic [7:0] rdata, output logic err,
                         output int phi_lo, output int phi_hi, output bit bus_ok, output bit idle_ok);
    int samp;
    bit seen;
    samp = 2 * HALF - 1 + ((k < MAXW) ? k : MAXW);
    lat = -1; rdata = 8'h00; err = 1'b0; phi_lo = 0; phi_hi = 0;
    bus_ok = 1'b1; idle_ok = 1'b0; seen = 1'b0;
    @(negedge clk);
    if (!mbi.cmd_ready) bus_ok = 1'b0;
    mbi.cmd_valid = 1'b1; mbi.cmd_rw = rw; mbi.cmd_addr = addr; mbi.cmd_wdata = wdata;
    for (int c = 0; c < 2 * HALF + MAXW + 4; c++) begin
      @(negedge clk);
      if (seen) begin
        idle_ok = mbi.cmd_ready && !mbi.rsp_valid && !mbi.bus_phi2 && mbi.bus_rwb &&
                  !mbi.bus_doe && (mbi.bus_addr == addr) && (mbi.bus_dout == wdata) &&
                  (mbi.rsp_rdata == rdata);
        break;
      end
      if (mbi.bus_addr !== addr || mbi.bus_rwb !== rw || mbi.bus_dout !== wdata ||
          mbi.bus_doe !== !rw) bus_ok = 1'b0;
      if (mbi.rsp_valid) begin
        seen = 1'b1; lat = c + 1; rdata = mbi.rsp_rdata; err = mbi.rsp_err;
        if (mbi.bus_phi2) bus_ok = 1'b0;
      end else if (mbi.bus_phi2) phi_hi++;
      else if (phi_hi == 0) phi_lo++;
      else bus_ok = 1'b0;
      mbi.cmd_valid = (noise && !seen) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        mbi.cmd_rw    = 1'($urandom_range(0, 1));
        mbi.cmd_addr  = 16'($urandom);
        mbi.cmd_wdata = 8'($urandom);
      end
      if (c < 2 * HALF - 1) mbi.bus_rdy = 1'($urandom_range(0, 1));
      else mbi.bus_rdy = (c < 2 * HALF - 1 + k) ? 1'b0 : 1'b1;
      mbi.bus_din = (c == samp) ? din : ~din;
    end
    mbi.cmd_valid = 1'b0;
    mbi.bus_rdy   = 1'b1;
  endtask

  task automatic judge(input string tag, input logic [7:0] e_rdata, input logic e_err, input int e_lat,
                       input int lat, input logic [7:0] rdata, input logic err,
                       input int phi_lo, input int phi_hi, input bit bus_ok, input bit idle_ok);
    check({tag, " latency"}, lat, e_lat);
    check({tag, " rdata"}, rdata, e_rdata);
    check({tag, " err"}, err, e_err);
    check({tag, " phi2_low"}, phi_lo, HALF);
    check({tag, " phi2_high"}, phi_hi, e_lat - HALF - 1);
    check({tag, " bus_stable"}, bus_ok, 1'b1);
    check({tag, " idle_after"}, idle_ok, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat, plo, phi;
    logic [7:0] rd;
    logic er;
    bit bok, iok;
    run_txn(v.rw, v.addr, v.wdata, v.din, v.k, 1'b0, lat, rd, er, plo, phi, bok, iok);
    judge(tag, v.exp_rdata, v.exp_err, v.exp_lat, lat, rd, er, plo, phi, bok, iok);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] q_addr[3];
    int          acc[$];
    logic [15:0] raddr[$];
    int          idx;
    bit          adv;
    int          rsp_cnt;

    n_tests = 0; n_fail = 0;
    vecs[0] = '{1'b1, 16'h6000, 8'h00, 8'hA5, 0,   8'hA5, 1'b0, 5};
    vecs[1] = '{1'b0, 16'h3FF0, 8'h5A, 8'h33, 0,   8'h00, 1'b0, 5};
    vecs[2] = '{1'b1, 16'h1234, 8'h00, 8'hC3, 3,   8'hC3, 1'b0, 8};
    vecs[3] = '{1'b1, 16'h8001, 8'h00, 8'h7E, 255, 8'h00, 1'b1, 9};
    vecs[4] = '{1'b1, 16'hFFFF, 8'h00, 8'h81, 4,   8'h81, 1'b0, 9};
    vecs[5] = '{1'b1, 16'h0000, 8'h00, 8'h18, 5,   8'h00, 1'b1, 9};
    vecs[6] = '{1'b0, 16'hABCD, 8'hE7, 8'h99, 2,   8'h00, 1'b0, 7};
    vecs[7] = '{1'b1, 16'h0F0F, 8'h00, 8'h01, 1,   8'h01, 1'b0, 6};

    rst_n = 1'b0;
    mbi.cmd_valid = 1'b0; mbi.cmd_rw = 1'b1; mbi.cmd_addr = 16'h0; mbi.cmd_wdata = 8'h0;
    mbi.bus_din = 8'h0; mbi.bus_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {mbi.bus_addr, mbi.bus_rwb, mbi.bus_phi2, mbi.bus_dout, mbi.bus_doe,
           mbi.rsp_valid, mbi.rsp_rdata, mbi.rsp_err, mbi.cmd_ready},
          {16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", mbi.cmd_ready, 1'b1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Three queued commands with cmd_valid held high.
    q_addr[0] = 16'h1000; q_addr[1] = 16'h2000; q_addr[2] = 16'h3000;
    @(negedge clk);
    mbi.cmd_valid = 1'b1; mbi.cmd_rw = 1'b1; mbi.cmd_addr = q_addr[0]; mbi.bus_rdy = 1'b1;
    idx = 0; adv = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (adv) begin
        idx++; adv = 1'b0;
        if (idx < 3) mbi.cmd_addr = q_addr[idx];
        else mbi.cmd_valid = 1'b0;
      end
      if (mbi.rsp_valid) raddr.push_back(mbi.bus_addr);
      if (mbi.cmd_valid && mbi.cmd_ready) begin
        acc.push_back(c);
        adv = 1'b1;
      end
      @(negedge clk);
    end
    mbi.cmd_valid = 1'b0;
    check("b2b_accepts", acc.size(), 3);
    for (int i = 1; i < 3; i++)
      check($sformatf("b2b_gap%0d", i), (acc.size() > i) ? acc[i] - acc[i-1] : -1, 2 * HALF + 2);
    check("b2b_responses", raddr.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("b2b_addr%0d", i), (raddr.size() > i) ? raddr[i] : 16'hxxxx, q_addr[i]);

    // Reset asserted while phi2 is high on a write.
    @(negedge clk);
    mbi.cmd_valid = 1'b1; mbi.cmd_rw = 1'b0; mbi.cmd_addr = 16'h4242; mbi.cmd_wdata = 8'h77;
    @(negedge clk);
    mbi.cmd_valid = 1'b0;
    repeat (HALF) @(negedge clk);
    check("pre_reset_access", {mbi.bus_phi2, mbi.bus_doe}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {mbi.bus_phi2, mbi.bus_doe, mbi.rsp_valid, mbi.bus_addr, mbi.cmd_ready},
          {1'b0, 1'b0, 1'b0, 16'h0000, 1'b1});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", mbi.cmd_ready, 1'b1);
    rsp_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (mbi.rsp_valid) rsp_cnt++;
      @(negedge clk);
    end
    check("no_rsp_after_abort", rsp_cnt, 0);
    run_vec(vecs[0], "post_reset_txn");

    for (int i = 0; i < NRAND; i++) begin
      logic rw;
      logic [15:0] addr;
      logic [7:0] wdata, din, e_rd, rd;
      logic e_er, er;
      int k, e_lat, lat, plo, phi;
      bit bok, iok;
      rw    = 1'($urandom_range(0, 1));
      addr  = 16'($urandom);
      wdata = 8'($urandom);
      din   = 8'($urandom);
      k     = $urandom_range(0, MAXW + 2);
      model(rw, din, k, e_rd, e_er, e_lat);
      run_txn(rw, addr, wdata, din, k, 1'b1, lat, rd, er, plo, phi, bok, iok);
      judge($sformatf("rand%0d", i), e_rd, e_er, e_lat, lat, rd, er, plo, phi, bok, iok);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
